rca_arbiter: RTL

- Round-robin arbiter and sequencer that shares one ripple_carry_adder instance among NUM_REQ independent requesters.
- Each requester presents an add/sub operation through a valid/ready handshake. The block grants one requester, registers its operands and drives the shared adder.
- The result and z/n/c/v flags are returned on a single response channel tagged with the requester id.
- It sits between the ALU-style clients and the adder datapath, so the adder stays single-instance.

---
 rtl/rca_arbiter.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/rca_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rca_arbiter (with ripple_carry_adder)
// Brief    : Round-robin arbiter sharing one ripple-carry adder among
//            NUM_REQ requesters; tagged response with z/n/c/v flags.
// Revision : 1.0 - initial release
// ============================================================================

module ripple_carry_adder #(
  parameter int BUS_WIDTH = 8
) (
  input  logic [BUS_WIDTH-1:0] in1,
  input  logic [BUS_WIDTH-1:0] in2,
  input  logic                 add_sub_b,
  input  logic                 sign,
  output logic [BUS_WIDTH-1:0] out,
  output logic                 z,
  output logic                 n,
  output logic                 c,
  output logic                 v
);

  logic [BUS_WIDTH-1:0] w_b;
  logic [BUS_WIDTH-1:0] w_sum;
  logic [BUS_WIDTH:0]   w_carry;

  // Subtract as in1 + ~in2 + 1, so carry-out = 1 means no borrow.
  assign w_b        = in2 ^ {BUS_WIDTH{add_sub_b}};
  assign w_carry[0] = add_sub_b;

  generate
    for (genvar i = 0; i < BUS_WIDTH; i++) begin : g_bit
      assign w_sum[i]     = in1[i] ^ w_b[i] ^ w_carry[i];
      assign w_carry[i+1] = (in1[i] & w_b[i]) | (w_carry[i] & (in1[i] ^ w_b[i]));
    end
  endgenerate

  assign out = w_sum;
  assign z   = ~|w_sum;
  assign n   = w_sum[BUS_WIDTH-1];
  assign c   = w_carry[BUS_WIDTH];
  // Overflow is only meaningful for two's-complement operands.
  assign v   = sign & (w_carry[BUS_WIDTH] ^ w_carry[BUS_WIDTH-1]);

endmodule

module rca_arbiter #(
  parameter int  BUS_WIDTH = 8,
  parameter int  NUM_REQ   = 4,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_add_sub_b,
  input  logic [NUM_REQ-1:0]            req_sign,
  input  logic [NUM_REQ*BUS_WIDTH-1:0]  req_in1,
  input  logic [NUM_REQ*BUS_WIDTH-1:0]  req_in2,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_W-1:0]               rsp_id,
  output logic [BUS_WIDTH-1:0]          rsp_out,
  output logic                          rsp_z,
  output logic                          rsp_n,
  output logic                          rsp_c,
  output logic                          rsp_v
);

  localparam int W1 = ID_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ID_W-1:0]      r_ptr;
  logic                 r_op_add_sub_b;
  logic                 r_op_sign;
  logic [BUS_WIDTH-1:0] r_op_in1;
  logic [BUS_WIDTH-1:0] r_op_in2;
  logic [ID_W-1:0]      r_op_id;

  logic [ID_W-1:0]      r_rsp_id;
  logic [BUS_WIDTH-1:0] r_rsp_out;
  logic                 r_rsp_z;
  logic                 r_rsp_n;
  logic                 r_rsp_c;
  logic                 r_rsp_v;

  logic                 w_found;
  logic [ID_W-1:0]      w_win;
  logic [W1-1:0]        w_scan;
  logic [ID_W-1:0]      w_idx;
  logic                 w_accept;
  logic [ID_W-1:0]      w_ptr_nxt;

  logic [BUS_WIDTH-1:0] w_add_out;
  logic                 w_add_z;
  logic                 w_add_n;
  logic                 w_add_c;
  logic                 w_add_v;

  // Scan from ptr upward, wrapping at NUM_REQ; the first valid wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_scan  = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_scan = {1'b0, r_ptr} + W1'(k);
      if (w_scan >= W1'(NUM_REQ)) begin
        w_scan = w_scan - W1'(NUM_REQ);
      end
      w_idx = w_scan[ID_W-1:0];
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_accept  = (r_state == ST_IDLE) && w_found;
  assign req_ready = w_accept ? (NUM_REQ'(1) << w_win) : '0;
  assign w_ptr_nxt = (w_win == ID_W'(NUM_REQ - 1)) ? '0 : (w_win + 1'b1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_found)   w_state_nxt = ST_EXEC;
      ST_EXEC:                w_state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  ripple_carry_adder #(
    .BUS_WIDTH (BUS_WIDTH)
  ) u_adder (
    .in1       (r_op_in1),
    .in2       (r_op_in2),
    .add_sub_b (r_op_add_sub_b),
    .sign      (r_op_sign),
    .out       (w_add_out),
    .z         (w_add_z),
    .n         (w_add_n),
    .c         (w_add_c),
    .v         (w_add_v)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr          <= '0;
      r_op_add_sub_b <= 1'b0;
      r_op_sign      <= 1'b0;
      r_op_in1       <= '0;
      r_op_in2       <= '0;
      r_op_id        <= '0;
      r_rsp_id       <= '0;
      r_rsp_out      <= '0;
      r_rsp_z        <= 1'b0;
      r_rsp_n        <= 1'b0;
      r_rsp_c        <= 1'b0;
      r_rsp_v        <= 1'b0;
    end else begin
      if (w_accept) begin
        r_ptr          <= w_ptr_nxt;
        r_op_add_sub_b <= req_add_sub_b[w_win];
        r_op_sign      <= req_sign[w_win];
        r_op_in1       <= req_in1[w_win*BUS_WIDTH +: BUS_WIDTH];
        r_op_in2       <= req_in2[w_win*BUS_WIDTH +: BUS_WIDTH];
        r_op_id        <= w_win;
      end
      // Response registers load once per operation and hold through RESP.
      if (r_state == ST_EXEC) begin
        r_rsp_id  <= r_op_id;
        r_rsp_out <= w_add_out;
        r_rsp_z   <= w_add_z;
        r_rsp_n   <= w_add_n;
        r_rsp_c   <= w_add_c;
        r_rsp_v   <= w_add_v;
      end
    end
  end

  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_id    = r_rsp_id;
  assign rsp_out   = r_rsp_out;
  assign rsp_z     = r_rsp_z;
  assign rsp_n     = r_rsp_n;
  assign rsp_c     = r_rsp_c;
  assign rsp_v     = r_rsp_v;

endmodule

`default_nettype wire
